// File: rtl/bram_window_reader.sv
// Scans a stored frame out of the frame BRAM as 3-pixel horizontal triplets in
// kernel-scan order: rows top to bottom, then the next column to the right.
module bram_window_reader #(
  parameter int RAM_WIDTH    = 8,
  parameter int RAM_DEPTH    = 2**16,
  parameter int IMAGE_WIDTH  = 10,
  parameter int IMAGE_HEIGHT = 10
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               i_start,
  output logic                               o_mem_en,
  output logic [clogb2(RAM_DEPTH-1)-1:0]     o_mem_addr,
  input  logic [RAM_WIDTH-1:0]               i_mem_data,
  output logic [3*RAM_WIDTH-1:0]             o_pixels,
  output logic                               o_valid,
  input  logic                               i_ready,
  output logic                               o_col_first,
  output logic                               o_busy,
  output logic                               o_frame_done
);

  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value;
    r = 0;
    while (v > 0) begin
      v = v >> 1;
      r = r + 1;
    end
    return r;
  endfunction

  localparam int AW = clogb2(RAM_DEPTH-1);
  localparam int W  = RAM_WIDTH;
  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 3);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
  localparam logic [AW-1:0] ROW_STEP = AW'(IMAGE_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_OUT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [AW-1:0]     base_q, base_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [3*W-1:0]    pix_q, pix_d;

  logic xfer;
  logic last_triplet;

  assign xfer         = (state_q == S_OUT) && i_ready;
  assign last_triplet = (col_q == COL_LAST) && (row_q == ROW_LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start) state_d = S_READ;
      S_READ:  if (idx_q == 2'd2) state_d = S_DRAIN;
      S_DRAIN: state_d = S_OUT;
      S_OUT:   if (xfer) state_d = last_triplet ? S_DONE : S_READ;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_mem_en     = (state_q == S_READ);
    o_valid      = (state_q == S_OUT);
    o_col_first  = (state_q == S_OUT) && (row_q == '0);
    o_busy       = (state_q != S_IDLE);
    o_frame_done = (state_q == S_DONE);
  end

  assign o_mem_addr = addr_q;
  assign o_pixels   = pix_q;

  // Scan counters, read index and pixel capture
  always_comb begin
    idx_d  = idx_q;
    col_d  = col_q;
    row_d  = row_q;
    base_d = base_q;
    pix_d  = pix_q;
    addr_d = addr_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          idx_d  = '0;
          col_d  = '0;
          row_d  = '0;
          base_d = '0;
        end
      end
      S_READ: begin
        idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        // Data for address base+idx-1 arrives one cycle after it was issued
        case (idx_q)
          2'd1:    pix_d[W-1:0]   = i_mem_data;
          2'd2:    pix_d[2*W-1:W] = i_mem_data;
          default: ;
        endcase
      end
      S_DRAIN: begin
        pix_d[3*W-1:2*W] = i_mem_data;
        idx_d            = '0;
      end
      S_OUT: begin
        if (xfer && !last_triplet) begin
          if (row_q != ROW_LAST) begin
            row_d  = row_q + 1'b1;
            base_d = base_q + ROW_STEP;
          end else begin
            row_d  = '0;
            col_d  = col_q + 1'b1;
            base_d = AW'(col_q) + AW'(1);
          end
        end
      end
      default: ;
    endcase

    // Address register follows the next READ cycle and otherwise holds
    if (state_d == S_READ) begin
      addr_d = base_d + AW'(idx_d);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q  <= '0;
      col_q  <= '0;
      row_q  <= '0;
      base_q <= '0;
      addr_q <= '0;
      pix_q  <= '0;
    end else begin
      idx_q  <= idx_d;
      col_q  <= col_d;
      row_q  <= row_d;
      base_q <= base_d;
      addr_q <= addr_d;
      pix_q  <= pix_d;
    end
  end

endmodule
